uart_tx_arbiter: RTL and testbench

Shares the single UART transmit serializer between several byte producers: shell command echo/response, CPU output port, debug dump. Each requester offers one byte at a time with a valid/ready handshake. The arbiter grants round-robin, drives the serializer's data-valid/byte inputs, and waits for the serializer's done pulse before the next byte. An optional packet lock lets one requester finish a multi-byte message (e.g. a hex dump line plus CR) without interleaving.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX serializer among NUM_REQ byte producers.
// Define TX_ARB_LOCK_EN to build the packet lock (HOLD state, i_Req_Last, idle timeout counter).
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done
);
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef TX_ARB_LOCK_EN
    localparam int unsigned CW = $clog2(LOCK_TIMEOUT);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, HOLD} state_t;
    logic          last_q;
    logic [CW-1:0] cnt;
`else
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;
    logic unused_c;
    assign unused_c = ^{i_Req_Last, 1'(LOCK_TIMEOUT % 2)};
`endif

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick_c;
    logic          any_c;
    logic [7:0]    lane_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane_byte[g] = i_Req_Byte[8*g +: 8];
    end

    // First valid lane at or after ptr, scanning upward with wrap.
    always_comb begin
        logic [PW-1:0] idx;
        idx    = '0;
        pick_c = '0;
        any_c  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PW'((32'(ptr) + i) % NUM_REQ);
            if (!any_c && i_Req_Valid[idx]) begin
                any_c  = 1'b1;
                pick_c = idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            o_Grant     <= '0;
            o_Req_Ready <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= 8'h00;
`ifdef TX_ARB_LOCK_EN
            last_q      <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            o_TX_DV     <= 1'b0;
            o_Req_Ready <= '0;
            case (state)
                IDLE: begin
                    // An external serializer user (i_TX_Active) blocks new grants.
                    if (any_c && !i_TX_Active) begin
                        owner       <= pick_c;
                        o_Grant     <= NUM_REQ'(1) << pick_c;
                        o_Req_Ready <= NUM_REQ'(1) << pick_c;
                        o_TX_DV     <= 1'b1;
                        o_TX_Byte   <= lane_byte[pick_c];
`ifdef TX_ARB_LOCK_EN
                        last_q      <= i_Req_Last[pick_c];
`endif
                        state       <= SEND;
                    end
                end
                SEND: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (i_TX_Done) begin
`ifdef TX_ARB_LOCK_EN
                        if (last_q) begin
                            ptr     <= PW'((32'(owner) + 32'd1) % NUM_REQ);
                            o_Grant <= '0;
                            state   <= IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= HOLD;
                        end
`else
                        ptr     <= PW'((32'(owner) + 32'd1) % NUM_REQ);
                        o_Grant <= '0;
                        state   <= IDLE;
`endif
                    end
                end
`ifdef TX_ARB_LOCK_EN
                HOLD: begin
                    // Only the owner may continue; others wait for release or timeout.
                    if (i_Req_Valid[owner]) begin
                        o_Req_Ready <= NUM_REQ'(1) << owner;
                        o_TX_DV     <= 1'b1;
                        o_TX_Byte   <= lane_byte[owner];
                        last_q      <= i_Req_Last[owner];
                        state       <= SEND;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        ptr     <= PW'((32'(owner) + 32'd1) % NUM_REQ);
                        o_Grant <= '0;
                        state   <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester and serializer models for uart_tx_arbiter.
module tb_uart_tx_arbiter;
    localparam int unsigned LTO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req_valid;
    logic [15:0] req_byte;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic        ser_active;
    logic        ext_active;

    assign tx_active = ser_active | ext_active;

    uart_tx_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(LTO)) dut (
        .CLK(CLK), .RST(RST),
        .i_Req_Valid(req_valid), .i_Req_Byte(req_byte), .i_Req_Last(req_last),
        .o_Req_Ready(req_ready), .o_Grant(grant),
        .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
        .i_TX_Active(tx_active), .i_TX_Done(tx_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        logic [1:0] g;
        int         gap;
    } exp_t;

    exp_t       sb [$];
    exp_t       e;
    logic [8:0] lane0_q [$];
    logic [8:0] lane1_q [$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ser_cnt = 0;
    int frame_len = 20;
    int done_cyc = -1000;
    int last_dv_cyc = 0;
    int n_dv = 0;
    logic       frame_ok = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    logic [1:0] cur_grant = 2'b00;

    // Requester lanes, serializer model and scoreboard, all sampled 1 time unit after the edge.
    initial begin
        req_valid  = '0;
        req_byte   = '0;
        req_last   = '0;
        tx_done    = 1'b0;
        ser_active = 1'b0;
        ext_active = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            tx_done = 1'b0;
            if (RST === 1'b1 && req_ready !== 2'b00 && tx_dv !== 1'b1) begin
                vectors++; miscompares++;
                $display("FAIL ready_without_dv: ready=%b dv=%b", req_ready, tx_dv);
            end
            if (req_ready[0] === 1'b1) begin
                if (lane0_q.size() == 0) begin
                    miscompares++; $display("FAIL lane0_ready_empty: ready=%b", req_ready);
                end else void'(lane0_q.pop_front());
            end
            if (req_ready[1] === 1'b1) begin
                if (lane1_q.size() == 0) begin
                    miscompares++; $display("FAIL lane1_ready_empty: ready=%b", req_ready);
                end else void'(lane1_q.pop_front());
            end
            if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    tx_done    = 1'b1;
                    ser_active = 1'b0;
                    done_cyc   = cyc;
                    if (frame_ok) begin
                        vectors++;
                        if (tx_byte !== cur_byte || grant !== cur_grant) begin
                            miscompares++;
                            $display("FAIL hold_until_done: byte=%h grant=%b expected byte=%h grant=%b",
                                     tx_byte, grant, cur_byte, cur_grant);
                        end
                    end
                    frame_ok = 1'b0;
                end
            end
            if (tx_dv === 1'b1) begin
                n_dv++;
                last_dv_cyc = cyc;
                vectors++;
                if (ser_cnt > 0 || sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_dv: byte=%h busy=%0d pending=%0d expected none", tx_byte, ser_cnt, sb.size());
                end else begin
                    e = sb.pop_front();
                    if (tx_byte !== e.b || grant !== e.g || req_ready !== e.g) begin
                        miscompares++;
                        $display("FAIL dv_payload: byte=%h grant=%b ready=%b expected byte=%h grant=%b ready=%b",
                                 tx_byte, grant, req_ready, e.b, e.g, e.g);
                    end
                    if (e.gap >= 0) begin
                        vectors++;
                        if (cyc - done_cyc != e.gap) begin
                            miscompares++;
                            $display("FAIL done_to_dv_gap: got %0d expected %0d", cyc - done_cyc, e.gap);
                        end
                    end
                    ser_cnt    = frame_len;
                    ser_active = 1'b1;
                    cur_byte   = tx_byte;
                    cur_grant  = e.g;
                    frame_ok   = 1'b1;
                end
            end
            req_valid[0]   = lane0_q.size() != 0;
            req_byte[7:0]  = (lane0_q.size() != 0) ? lane0_q[0][7:0] : 8'h00;
            req_last[0]    = (lane0_q.size() != 0) ? lane0_q[0][8] : 1'b0;
            req_valid[1]   = lane1_q.size() != 0;
            req_byte[15:8] = (lane1_q.size() != 0) ? lane1_q[0][7:0] : 8'h00;
            req_last[1]    = (lane1_q.size() != 0) ? lane1_q[0][8] : 1'b0;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic push(input int lane, input logic last, input logic [7:0] b, input int gap);
        exp_t x;
        x.b = b; x.g = (lane == 0) ? 2'b01 : 2'b10; x.gap = gap;
        if (lane == 0) lane0_q.push_back({last, b});
        else lane1_q.push_back({last, b});
        sb.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || ser_cnt != 0 || lane0_q.size() != 0 || lane1_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_drain: pending=%0d busy=%0d expected empty within %0d cycles", name, sb.size(), ser_cnt, budget);
            sb.delete(); lane0_q.delete(); lane1_q.delete();
        end
        tick(3);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        frame_ok = 1'b0;
        tick(3);
        RST = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick(4);
        vectors += 4;
        if (grant !== 2'b00)     begin miscompares++; $display("FAIL reset_grant: got %b expected 00", grant); end
        if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        if (tx_dv !== 1'b0)      begin miscompares++; $display("FAIL reset_dv: got %b expected 0", tx_dv); end
        if (tx_byte !== 8'h00)   begin miscompares++; $display("FAIL reset_byte: got %h expected 00", tx_byte); end
        RST = 1'b1;
        tick(3);
        vectors++;
        if (tx_dv !== 1'b0 || grant !== 2'b00) begin
            miscompares++; $display("FAIL idle_after_reset: dv=%b grant=%b expected 0/00", tx_dv, grant);
        end
    endtask

    task automatic test_single_lane();
        do_reset();
        frame_len = 8680;
        push(0, 1'b0, 8'h67, -1);
        push(0, 1'b1, 8'h0D, 2);
        wait_drain("single_lane", 20000);
        vectors++;
        if (n_dv != 2) begin miscompares++; $display("FAIL single_lane_dv_count: got %0d expected 2", n_dv); end
        frame_len = 20;
    endtask

    task automatic test_contention();
        do_reset();
        push(0, 1'b1, 8'h41, -1);
        push(1, 1'b1, 8'h42, 2);
        push(0, 1'b1, 8'h41, 2);
        push(1, 1'b1, 8'h42, 2);
        wait_drain("contention", 500);
    endtask

    task automatic test_busy_guard();
        int n0, c0, n;
        do_reset();
        ext_active = 1'b1;
        push(0, 1'b1, 8'h55, -1);
        n0 = n_dv;
        tick(10);
        vectors++;
        if (n_dv != n0) begin miscompares++; $display("FAIL busy_guard_dv: got %0d pulses expected 0", n_dv - n0); end
        ext_active = 1'b0;
        c0 = cyc;
        n = 0;
        while (n_dv == n0 && n < 20) begin tick(1); n++; end
        vectors++;
        if (n_dv == n0 || last_dv_cyc != c0 + 1) begin
            miscompares++;
            $display("FAIL busy_release_dv: got cycle %0d expected %0d", last_dv_cyc - c0, 1);
        end
        wait_drain("busy_guard", 200);
    endtask

    task automatic test_reset_mid();
        int n0, n;
        do_reset();
        frame_len = 40;
        n0 = n_dv;
        push(0, 1'b1, 8'h11, -1);
        n = 0;
        while (n_dv == n0 && n < 20) begin tick(1); n++; end
        tick(5);
        RST = 1'b0;
        frame_ok = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00 || tx_dv !== 1'b0 || req_ready !== 2'b00 || tx_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: grant=%b dv=%b ready=%b byte=%h expected all zero",
                     grant, tx_dv, req_ready, tx_byte);
        end
        tick(2);
        push(1, 1'b1, 8'h22, -1);
        RST = 1'b1;
        wait_drain("reset_mid", 300);
        frame_len = 20;
    endtask

`ifdef TX_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        push(0, 1'b0, 8'h41, -1);
        push(0, 1'b1, 8'h42, 2);
        push(1, 1'b1, 8'h5A, 2);
        wait_drain("lock", 500);
    endtask

    task automatic test_lock_timeout();
        do_reset();
        push(0, 1'b0, 8'h41, -1);
        push(1, 1'b1, 8'h5A, int'(LTO) + 2);
        wait_drain("lock_timeout", 500);
    endtask
`else
    task automatic test_no_lock();
        do_reset();
        push(0, 1'b0, 8'h41, -1);
        push(1, 1'b1, 8'h5A, 2);
        push(0, 1'b1, 8'h42, 2);
        wait_drain("no_lock", 500);
    endtask
`endif

    initial begin
        RST = 1'b0;
        test_reset();
        test_single_lane();
        test_contention();
        test_busy_guard();
        test_reset_mid();
`ifdef TX_ARB_LOCK_EN
        test_lock();
        test_lock_timeout();
`else
        test_no_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
